// File: rtl/branch_pkg.sv
// Shared definitions for the branch controller slice.
// Contents:
//   F3_*          conditional-branch funct3 encodings (RV32I)
//   brc_state_e   recovery FSM states
//   BHT_RST       power-up value of every BHT counter (weakly not-taken)
//   br_legal      funct3 names a real conditional branch
//   br_decide     taken decision from funct3 and comparator flags
//   bht_next      2-bit saturating counter update
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } brc_state_e;

    localparam logic [1:0] BHT_RST = 2'b01;

    // 010 and 011 are the only unused encodings in the branch major opcode.
    function automatic logic br_legal(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

    // Signed/unsigned is already folded into the comparator via
    // br_unsigned_o, so BLT/BLTU and BGE/BGEU share one term each.
    function automatic logic br_decide(input logic [2:0] funct3,
                                       input logic       less,
                                       input logic       equal);
        logic taken;
        taken = 1'b0;
        unique case (funct3)
            F3_BEQ:           taken = equal;
            F3_BNE:           taken = !equal;
            F3_BLT, F3_BLTU:  taken = less;
            F3_BGE, F3_BGEU:  taken = !less;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic [1:0] bht_next(input logic [1:0] ctr,
                                            input logic       taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: an array of 2-bit saturating counters.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   rd_idx_i        combinational read index (fetch side)
//   rd_ctr_o        counter at rd_idx_i, pre-update value
//   upd_en_i        apply an outcome this cycle
//   upd_idx_i       entry to update (execute side)
//   upd_taken_i     outcome: increment when 1, decrement when 0
module bht_2bit
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] ctr_q [ENTRIES];

    // Read is straight off the flops, so a same-index write in this cycle
    // is only visible after the edge.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    // NOTE: the table is built from flops, not a RAM macro, so every entry
    // is reset; a RAM would need a separate init sweep instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_RST;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= bht_next(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution, misprediction recovery and direction prediction.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   if_pc_i              fetch PC; if_pred_taken_o is its BHT prediction
//   ex_*                 EX-stage instruction: valid, kind, funct3, PC,
//                        target and the prediction it was fetched with
//   stall_i              EX frozen: nothing resolves this cycle
//   br_less_i/equal_i    comparator flags; br_unsigned_o selects unsigned
//   redirect_o/_pc_o     registered fetch redirect and recovery PC
//   flush_o              registered kill of IF/ID and ID/EX
//   br_cnt_o             resolved conditional branches
//   mispred_cnt_o        mispredicted conditional branches
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] if_pc_i,
    output logic        if_pred_taken_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_br_i,
    input  logic        ex_is_jmp_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic        stall_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        br_unsigned_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    brc_state_e  state_q, state_d;
    logic        resolve;
    logic        jmp_hit;
    logic        br_hit;
    logic        taken;
    logic        mispred;
    logic        redirect_req;
    logic [31:0] recover_pc;
    logic [1:0]  if_ctr;
    logic        redirect_q, flush_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] br_cnt_q, mispred_cnt_q;
    logic        unused_pc_bits;

    // funct3[1] is set exactly for BLTU/BGEU among the legal branches.
    assign br_unsigned_o = ex_funct3_i[1];

    // ------------------------------------------------------------------
    // Predictor
    // ------------------------------------------------------------------
    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rd_idx_i    (if_pc_i[IDX_W+1:2]),
        .rd_ctr_o    (if_ctr),
        .upd_en_i    (br_hit),
        .upd_idx_i   (ex_pc_i[IDX_W+1:2]),
        .upd_taken_i (taken)
    );

    assign if_pred_taken_o = if_ctr[1];

    // Instruction-alignment bits and high PC bits never address the table.
    assign unused_pc_bits = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0]};

    // ------------------------------------------------------------------
    // Resolution
    // ------------------------------------------------------------------
    // In RECOVER the EX slot holds a wrong-path instruction that is being
    // flushed, so it must not resolve.
    assign resolve = ex_valid_i && !stall_i && (state_q == NORMAL);

    // A jump flag wins over the branch flag. An illegal funct3 is left to
    // the decoder's exception path: it neither trains, counts nor redirects.
    assign jmp_hit = resolve && ex_is_jmp_i;
    assign br_hit  = resolve && ex_is_br_i && !ex_is_jmp_i
                     && br_legal(ex_funct3_i);
    assign taken   = br_decide(ex_funct3_i, br_less_i, br_equal_i);
    assign mispred = br_hit && (taken != ex_pred_taken_i);

    assign redirect_req = jmp_hit || mispred;

    // Not-taken recovery falls through; the +4 wraps at 2^32 on purpose.
    assign recover_pc = (jmp_hit || taken) ? ex_target_i : ex_pc_i + 32'd4;

    // ------------------------------------------------------------------
    // Recovery FSM
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment before the case keeps this block purely
    // combinational; a missed path would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL:  if (redirect_req) state_d = RECOVER;
            RECOVER: state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // redirect/flush are loaded at the same edge that enters RECOVER and
    // clear at the edge that leaves it; resolve is low in RECOVER, so
    // redirect_req alone gives exactly one high cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= redirect_req;
            flush_q    <= redirect_req;
            if (redirect_req) begin
                redirect_pc_q <= recover_pc;
            end
        end
    end

    assign redirect_o    = redirect_q;
    assign flush_o       = flush_q;
    assign redirect_pc_o = redirect_pc_q;

    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (br_hit) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispred) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: reset, BEQ mispredict, BGEU correct
// prediction, PC wrap and saturation, jump with wrong-path RECOVER slot,
// stall, and reset asserted during RECOVER.
module tb_branch_ctrl;
    import branch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_o;
    logic        ex_valid_i, ex_is_br_i, ex_is_jmp_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i, ex_target_i;
    logic        ex_pred_taken_i, stall_i, br_less_i, br_equal_i;
    logic        br_unsigned_o, redirect_o, flush_o;
    logic [31:0] redirect_pc_o, br_cnt_o, mispred_cnt_o;

    int errors = 0;
    int checks = 0;

    branch_ctrl #(.BHT_ENTRIES(64)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (if_pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_is_br_i      (ex_is_br_i),
        .ex_is_jmp_i     (ex_is_jmp_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_pc_i         (ex_pc_i),
        .ex_target_i     (ex_target_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .stall_i         (stall_i),
        .br_less_i       (br_less_i),
        .br_equal_i      (br_equal_i),
        .br_unsigned_o   (br_unsigned_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
        .br_cnt_o        (br_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_ex(input logic valid, input logic is_br, input logic is_jmp,
                            input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic pred,
                            input logic less, input logic equal);
        ex_valid_i      = valid;
        ex_is_br_i      = is_br;
        ex_is_jmp_i     = is_jmp;
        ex_funct3_i     = f3;
        ex_pc_i         = pc;
        ex_target_i     = tgt;
        ex_pred_taken_i = pred;
        br_less_i       = less;
        br_equal_i      = equal;
    endtask

    task automatic ex_idle();
        drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        stall_i = 1'b0;
        if_pc_i = 32'h100;
        ex_idle();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred got=%0b exp=0", if_pred_taken_o); end
        checks++; if (br_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_br_cnt got=%0d exp=0", br_cnt_o); end
        checks++; if (mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_mispred_cnt got=%0d exp=0", mispred_cnt_o); end
        checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%0b/%0b exp=0/0", redirect_o, flush_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc_o); end
    endtask

    // BEQ at 0x100 taken, predicted not-taken: mispredict to target.
    task automatic test_beq_mispred();
        drive_ex(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h180, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (br_unsigned_o !== 1'b0) begin errors++; $display("FAIL beq_unsigned got=%0b exp=0", br_unsigned_o); end
        step();
        ex_idle();
        checks++; if (redirect_o !== 1'b1 || flush_o !== 1'b1) begin errors++; $display("FAIL beq_redirect got=%0b/%0b exp=1/1", redirect_o, flush_o); end
        checks++; if (redirect_pc_o !== 32'h180) begin errors++; $display("FAIL beq_redirect_pc got=%h exp=00000180", redirect_pc_o); end
        checks++; if (br_cnt_o !== 32'd1 || mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL beq_counts got=%0d/%0d exp=1/1", br_cnt_o, mispred_cnt_o); end
        step();
        checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL beq_recover_end got=%0b/%0b exp=0/0", redirect_o, flush_o); end
        checks++; if (redirect_pc_o !== 32'h180) begin errors++; $display("FAIL beq_pc_hold got=%h exp=00000180", redirect_pc_o); end
        if_pc_i = 32'h100;
        #1;
        checks++; if (if_pred_taken_o !== 1'b1) begin errors++; $display("FAIL beq_bht_trained got=%0b exp=1", if_pred_taken_o); end
    endtask

    // BGEU not-less with taken prediction: correct, no redirect.
    task automatic test_bgeu_correct();
        drive_ex(1'b1, 1'b1, 1'b0, F3_BGEU, 32'h304, 32'h900, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (br_unsigned_o !== 1'b1) begin errors++; $display("FAIL bgeu_unsigned got=%0b exp=1", br_unsigned_o); end
        step();
        ex_idle();
        checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL bgeu_no_redirect got=%0b/%0b exp=0/0", redirect_o, flush_o); end
        checks++; if (br_cnt_o !== 32'd2 || mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL bgeu_counts got=%0d/%0d exp=2/1", br_cnt_o, mispred_cnt_o); end
        if_pc_i = 32'h304;
        #1;
        checks++; if (if_pred_taken_o !== 1'b1) begin errors++; $display("FAIL bgeu_bht got=%0b exp=1", if_pred_taken_o); end
    endtask

    // BNE at the top of the address space: fall-through wraps to 0, then
    // saturation of entry 63 and the read-before-write collision.
    task automatic test_bne_wrap();
        if_pc_i = 32'hFFFF_FFFC;
        drive_ex(1'b1, 1'b1, 1'b0, F3_BNE, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL bne_taken_redirect got=%0b exp=0", redirect_o); end
        br_equal_i = 1'b1;
        step();
        ex_idle();
        checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0) begin errors++; $display("FAIL bne_wrap got=%0b/%h exp=1/00000000", redirect_o, redirect_pc_o); end
        checks++; if (br_cnt_o !== 32'd4 || mispred_cnt_o !== 32'd2) begin errors++; $display("FAIL bne_counts got=%0d/%0d exp=4/2", br_cnt_o, mispred_cnt_o); end
        step();
        // Entry 63 is back at 01; four taken resolutions back to back.
        drive_ex(1'b1, 1'b1, 1'b0, F3_BNE, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL bht_collision_old got=%0b exp=0", if_pred_taken_o); end
        repeat (4) step();
        checks++; if (if_pred_taken_o !== 1'b1 || redirect_o !== 1'b0) begin errors++; $display("FAIL bht_sat_up got=%0b/%0b exp=1/0", if_pred_taken_o, redirect_o); end
        // Two correct not-taken resolutions: 11 -> 10 -> 01.
        drive_ex(1'b1, 1'b1, 1'b0, F3_BNE, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (if_pred_taken_o !== 1'b1) begin errors++; $display("FAIL bht_sat_dec1 got=%0b exp=1", if_pred_taken_o); end
        step();
        ex_idle();
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL bht_sat_dec2 got=%0b exp=0", if_pred_taken_o); end
        checks++; if (br_cnt_o !== 32'd10 || mispred_cnt_o !== 32'd2) begin errors++; $display("FAIL sat_counts got=%0d/%0d exp=10/2", br_cnt_o, mispred_cnt_o); end
    endtask

    // JAL (branch flag also set) redirects; the RECOVER-cycle branch is ignored.
    task automatic test_jump_recover();
        drive_ex(1'b1, 1'b1, 1'b1, F3_BEQ, 32'h200, 32'h400, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (redirect_o !== 1'b1 || flush_o !== 1'b1 || redirect_pc_o !== 32'h400) begin errors++; $display("FAIL jal_redirect got=%0b/%0b/%h exp=1/1/00000400", redirect_o, flush_o, redirect_pc_o); end
        checks++; if (br_cnt_o !== 32'd10) begin errors++; $display("FAIL jal_no_count got=%0d exp=10", br_cnt_o); end
        drive_ex(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h308, 32'h500, 1'b0, 1'b0, 1'b1);
        step();
        ex_idle();
        checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0 || redirect_pc_o !== 32'h400) begin errors++; $display("FAIL recover_ignore got=%0b/%0b/%h exp=0/0/00000400", redirect_o, flush_o, redirect_pc_o); end
        checks++; if (br_cnt_o !== 32'd10 || mispred_cnt_o !== 32'd2) begin errors++; $display("FAIL recover_counts got=%0d/%0d exp=10/2", br_cnt_o, mispred_cnt_o); end
        if_pc_i = 32'h308;
        #1;
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL recover_bht got=%0b exp=0", if_pred_taken_o); end
    endtask

    // Mispredicting BEQ held by stall, then released; stall in RECOVER.
    task automatic test_stall();
        drive_ex(1'b1, 1'b1, 1'b0, F3_BEQ, 32'h30C, 32'h600, 1'b0, 1'b0, 1'b1);
        stall_i = 1'b1;
        repeat (2) step();
        checks++; if (redirect_o !== 1'b0 || br_cnt_o !== 32'd10) begin errors++; $display("FAIL stall_hold got=%0b/%0d exp=0/10", redirect_o, br_cnt_o); end
        stall_i = 1'b0;
        step();
        ex_idle();
        stall_i = 1'b1;
        checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h600) begin errors++; $display("FAIL stall_release got=%0b/%h exp=1/00000600", redirect_o, redirect_pc_o); end
        checks++; if (br_cnt_o !== 32'd11 || mispred_cnt_o !== 32'd3) begin errors++; $display("FAIL stall_counts got=%0d/%0d exp=11/3", br_cnt_o, mispred_cnt_o); end
        step();
        stall_i = 1'b0;
        checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL stall_recover_len got=%0b/%0b exp=0/0", redirect_o, flush_o); end
    endtask

    // Reset pulsed in the middle of RECOVER.
    task automatic test_reset_mid_recover();
        drive_ex(1'b1, 1'b0, 1'b1, 3'b000, 32'h210, 32'h700, 1'b0, 1'b0, 1'b0);
        step();
        ex_idle();
        checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h700) begin errors++; $display("FAIL jalr_redirect got=%0b/%h exp=1/00000700", redirect_o, redirect_pc_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL async_clear got=%0b/%0b exp=0/0", redirect_o, flush_o); end
        checks++; if (redirect_pc_o !== 32'h0 || br_cnt_o !== 32'd0 || mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL async_regs got=%h/%0d/%0d exp=0/0/0", redirect_pc_o, br_cnt_o, mispred_cnt_o); end
        if_pc_i = 32'h100;
        #1;
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL async_bht0 got=%0b exp=0", if_pred_taken_o); end
        if_pc_i = 32'h304;
        #1;
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL async_bht1 got=%0b exp=0", if_pred_taken_o); end
        #1 rst_ni = 1'b1;
        step();
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL post_reset_redirect got=%0b exp=0", redirect_o); end
    endtask

    initial begin
        test_reset();
        test_beq_mispred();
        test_bgeu_correct();
        test_bne_wrap();
        test_jump_recover();
        test_stall();
        test_reset_mid_recover();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
